display_source_scheduler: RTL and testbench

- Shares the 8-digit seven-segment display datapath between four 32-bit debug sources (e.g. PC, ALU result, register read data, memory read data).
- Runs in one of three ways: auto-rotation on a dwell timer, manual stepping from a debounced push-button, or temporary priority override granted to a requesting source.
- Drives the 32-bit data_to_show bus consumed by the display scan/decode block.

---
 rtl/display_source_scheduler.sv | 145 ++++++++++++++
 tb/tb_display_source_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/display_source_scheduler.sv
// display_source_scheduler: shares the 7-seg datapath between four 32-bit debug sources.
// Define DISP_SRC_TAG_EN to replace the top nibble of data_to_show with the source index.
module display_source_scheduler #(
   parameter int DWELL    = 50000000,
   parameter int DEBOUNCE = 1000000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] src_data,
   input  logic [3:0]   src_req,
   input  logic         mode_auto,
   input  logic         btn_next,
   output logic [31:0]  data_to_show,
   output logic [1:0]   src_sel,
   output logic [3:0]   grant,
   output logic         override_active
);
   localparam int DW  = $clog2(DWELL);
   localparam int DBW = $clog2(DEBOUNCE);

   typedef enum logic [1:0] {SCAN, MANUAL, OVERRIDE} state_t;

   state_t           state_q, state_d;
   logic [1:0]       src_sel_q, src_sel_d, saved_sel_q, saved_sel_d, rr_ptr_q, rr_ptr_d;
   logic [3:0]       grant_q, grant_d;
   logic [DW-1:0]    dwell_q, dwell_d;
   logic [31:0]      data_q, data_d;
   logic             sync1_q, sync2_q, fired_q, fired_d;
   logic [DBW-1:0]   db_cnt_q, db_cnt_d;
   logic             db_full, step, dwell_last, start_ovr;
   logic [1:0]       winner, idx;
   logic [31:0]      slice;

   assign db_full    = db_cnt_q == DBW'(DEBOUNCE - 1);
   assign step       = sync2_q & db_full & ~fired_q;
   assign dwell_last = dwell_q == DW'(DWELL - 1);

   // Counter saturates so a held button yields exactly one pulse; fired_q re-arms on release.
   always_comb begin
      db_cnt_d = sync2_q ? (db_full ? db_cnt_q : db_cnt_q + 1'b1) : '0;
      fired_d  = sync2_q & (fired_q | step);
   end

   // First requesting source at or after rr_ptr, wrapping; descending loop lets the nearest win.
   always_comb begin
      winner = rr_ptr_q;
      idx    = rr_ptr_q;
      for (int i = 3; i >= 0; i--) begin
         idx = rr_ptr_q + 2'(i);
         if (src_req[idx]) winner = idx;
      end
   end

   always_comb begin
      state_d     = state_q;
      src_sel_d   = src_sel_q;
      saved_sel_d = saved_sel_q;
      grant_d     = grant_q;
      dwell_d     = dwell_q;
      rr_ptr_d    = rr_ptr_q;
      start_ovr   = 1'b0;
      case (state_q)
         SCAN: begin
            if (|src_req) begin
               start_ovr   = 1'b1;
               saved_sel_d = src_sel_q;
            end else if (!mode_auto) begin
               state_d = MANUAL;
               dwell_d = '0;
            end else begin
               dwell_d   = dwell_last ? '0 : dwell_q + 1'b1;
               src_sel_d = dwell_last ? src_sel_q + 2'd1 : src_sel_q;
            end
         end
         MANUAL: begin
            dwell_d = '0;
            if (|src_req) begin
               start_ovr   = 1'b1;
               saved_sel_d = src_sel_q;
            end else if (mode_auto) state_d = SCAN;
            else if (step) src_sel_d = src_sel_q + 2'd1;
         end
         OVERRIDE: begin
            if (!dwell_last) dwell_d = dwell_q + 1'b1;
            else if (|src_req) start_ovr = 1'b1;
            else begin
               state_d   = mode_auto ? SCAN : MANUAL;
               src_sel_d = saved_sel_q;
               grant_d   = '0;
               dwell_d   = '0;
            end
         end
         default: state_d = SCAN;
      endcase
      if (start_ovr) begin
         state_d   = OVERRIDE;
         src_sel_d = winner;
         grant_d   = 4'b0001 << winner;
         dwell_d   = '0;
         rr_ptr_d  = winner + 2'd1;
      end
   end

   always_comb begin
      slice = src_data[32*src_sel_q +: 32];
`ifdef DISP_SRC_TAG_EN
      data_d = {2'b00, src_sel_q, slice[27:0]};
`else
      data_d = slice;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SCAN;
         src_sel_q   <= '0;
         saved_sel_q <= '0;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         dwell_q     <= '0;
         data_q      <= '0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         fired_q     <= 1'b0;
         db_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         src_sel_q   <= src_sel_d;
         saved_sel_q <= saved_sel_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         dwell_q     <= dwell_d;
         data_q      <= data_d;
         sync1_q     <= btn_next;
         sync2_q     <= sync1_q;
         fired_q     <= fired_d;
         db_cnt_q    <= db_cnt_d;
      end
   end

   assign data_to_show    = data_q;
   assign src_sel         = src_sel_q;
   assign grant           = grant_q;
   assign override_active = state_q == OVERRIDE;
endmodule

// File: tb/tb_display_source_scheduler.sv
// tb_display_source_scheduler: directed checks of rotation, stepping, override and reset.
module tb_display_source_scheduler;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] src_data;
   logic [3:0]   src_req = '0;
   logic         mode_auto = 1'b1;
   logic         btn_next = 1'b0;
   logic [31:0]  data_to_show;
   logic [1:0]   src_sel;
   logic [3:0]   grant;
   logic         override_active;
   logic [31:0]  src [4];
   int           checks = 0;
   int           failures = 0;

   display_source_scheduler #(.DWELL(4), .DEBOUNCE(3)) dut (
      .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_req(src_req),
      .mode_auto(mode_auto), .btn_next(btn_next), .data_to_show(data_to_show),
      .src_sel(src_sel), .grant(grant), .override_active(override_active)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required end of test");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] expd(input int k);
      logic [31:0] v;
      v = src[k];
`ifdef DISP_SRC_TAG_EN
      v[31:28] = 4'(k);
`endif
      return v;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset(input logic ma);
      rst_n = 1'b0; mode_auto = ma; src_req = '0; btn_next = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      tick();
      checks++; if (src_sel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", src_sel); end
      checks++; if (grant !== 4'd0) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
      checks++; if (override_active !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", override_active); end
      checks++; if (data_to_show !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_to_show); end
   endtask

   task automatic test_scan();
      logic [1:0] es;
      do_reset(1'b1);
      for (int k = 1; k <= 17; k++) begin
         tick();
         es = 2'((k / 4) % 4);
         checks++; if (src_sel !== es) begin failures++; $display("FAIL scan_sel k=%0d got=%0d exp=%0d", k, src_sel, es); end
         checks++; if (data_to_show !== expd(((k - 1) / 4) % 4)) begin failures++; $display("FAIL scan_data k=%0d got=%h exp=%h", k, data_to_show, expd(((k - 1) / 4) % 4)); end
      end
   endtask

   task automatic test_manual();
      do_reset(1'b0);
      tick();
      btn_next = 1'b1; tick();
      btn_next = 1'b0; tick();
      btn_next = 1'b1; repeat (6) tick();
      btn_next = 1'b0; repeat (4) tick();
      checks++; if (src_sel !== 2'd1) begin failures++; $display("FAIL manual_bounce got=%0d exp=1", src_sel); end
      for (int p = 2; p <= 4; p++) begin
         btn_next = 1'b1; repeat (6) tick();
         btn_next = 1'b0; repeat (4) tick();
         checks++; if (src_sel !== 2'(p % 4)) begin failures++; $display("FAIL manual_press p=%0d got=%0d exp=%0d", p, src_sel, p % 4); end
      end
   endtask

   task automatic test_override();
      do_reset(1'b1);
      repeat (8) tick();
      checks++; if (src_sel !== 2'd2) begin failures++; $display("FAIL ovr_pre got=%0d exp=2", src_sel); end
      src_req = 4'b1000; tick(); src_req = '0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) tick();
         checks++; if (src_sel !== 2'd3 || grant !== 4'b1000 || override_active !== 1'b1) begin
            failures++; $display("FAIL ovr_hold c=%0d got sel=%0d grant=%b ovr=%b exp sel=3 grant=1000 ovr=1", c, src_sel, grant, override_active);
         end
         if (c == 1) begin
            checks++; if (data_to_show !== expd(3)) begin failures++; $display("FAIL ovr_data got=%h exp=%h", data_to_show, expd(3)); end
         end
      end
      tick();
      checks++; if (src_sel !== 2'd2 || grant !== 4'd0 || override_active !== 1'b0) begin
         failures++; $display("FAIL ovr_exit got sel=%0d grant=%b ovr=%b exp sel=2 grant=0000 ovr=0", src_sel, grant, override_active);
      end
      repeat (3) tick();
      checks++; if (src_sel !== 2'd2) begin failures++; $display("FAIL ovr_dwell_restart got=%0d exp=2", src_sel); end
      tick();
      checks++; if (src_sel !== 2'd3) begin failures++; $display("FAIL ovr_rollover got=%0d exp=3", src_sel); end
   endtask

   task automatic test_round_robin();
      logic [1:0] w [3];
      w[0] = 2'd0; w[1] = 2'd2; w[2] = 2'd0;
      src_req = 4'b0101;
      for (int o = 0; o < 3; o++) begin
         for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (src_sel !== w[o] || grant !== (4'b0001 << w[o]) || override_active !== 1'b1) begin
               failures++; $display("FAIL rr o=%0d c=%0d got sel=%0d grant=%b ovr=%b exp sel=%0d ovr=1", o, c, src_sel, grant, override_active, w[o]);
            end
            if (o == 2 && c == 0) src_req = '0;
         end
      end
      tick();
      checks++; if (src_sel !== 2'd3 || override_active !== 1'b0) begin
         failures++; $display("FAIL rr_exit got sel=%0d ovr=%b exp sel=3 ovr=0", src_sel, override_active);
      end
   endtask

   task automatic test_btn_during_override();
      do_reset(1'b0);
      tick();
      src_req = 4'b0010; btn_next = 1'b1; tick(); src_req = '0;
      checks++; if (src_sel !== 2'd1 || grant !== 4'b0010) begin failures++; $display("FAIL bdo_entry got sel=%0d grant=%b exp sel=1 grant=0010", src_sel, grant); end
      tick(); mode_auto = 1'b1;
      tick(); tick();
      checks++; if (src_sel !== 2'd1 || override_active !== 1'b1) begin failures++; $display("FAIL bdo_hold got sel=%0d ovr=%b exp sel=1 ovr=1", src_sel, override_active); end
      tick();
      checks++; if (src_sel !== 2'd0 || grant !== 4'd0 || override_active !== 1'b0) begin
         failures++; $display("FAIL bdo_exit got sel=%0d grant=%b ovr=%b exp sel=0 grant=0000 ovr=0", src_sel, grant, override_active);
      end
      repeat (3) tick();
      checks++; if (src_sel !== 2'd0) begin failures++; $display("FAIL bdo_scan_hold got=%0d exp=0", src_sel); end
      tick();
      checks++; if (src_sel !== 2'd1) begin failures++; $display("FAIL bdo_scan_step got=%0d exp=1", src_sel); end
      btn_next = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset(1'b1);
      tick();
      src_req = 4'b0100; tick(); src_req = '0;
      checks++; if (src_sel !== 2'd2 || grant !== 4'b0100) begin failures++; $display("FAIL ar_entry got sel=%0d grant=%b exp sel=2 grant=0100", src_sel, grant); end
      tick();
      checks++; if (data_to_show !== expd(2)) begin failures++; $display("FAIL ar_data got=%h exp=%h", data_to_show, expd(2)); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (src_sel !== 2'd0 || grant !== 4'd0 || override_active !== 1'b0 || data_to_show !== 32'd0) begin
         failures++; $display("FAIL ar_async got sel=%0d grant=%b ovr=%b data=%h exp all zero", src_sel, grant, override_active, data_to_show);
      end
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      src[0] = 32'h11111111; src[1] = 32'h22222222; src[2] = 32'h33333333; src[3] = 32'h44444444;
      src_data = {src[3], src[2], src[1], src[0]};
      test_reset();
      test_scan();
      test_manual();
      test_override();
      test_round_robin();
      test_btn_during_override();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
